// File: rtl/matmul_engine_pkg.sv
// Shared definitions for the matrix-multiply engine and its bench.
// Holds the default element width and maximum dimension, the derived
// dimension and accumulator widths, the element/accumulator types and
// the controller state encoding.
package matmul_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int M_DEF          = 32;

  // Dimensions run 1..M inclusive, so one extra bit over $clog2(M).
  localparam int DIM_W = $clog2(M_DEF) + 1;

  // A full product plus log2(M) growth bits holds any sum of M products.
  localparam int ACC_W = 2 * DATA_WIDTH_DEF + $clog2(M_DEF);

  typedef logic signed [DATA_WIDTH_DEF-1:0] element_t;
  typedef logic signed [ACC_W-1:0]          acc_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    MAC,
    EMIT
  } state_t;

endpackage

// File: rtl/matmul_engine_if.sv
// Operand and result stream bundle for matmul_engine.
// in_valid/in_ready/in_data : operand stream (A row-major, then B row-major)
// out_valid/out_ready/out_data : result stream (C row-major)
// master : the side that feeds operands and consumes results
// slave  : the engine itself
interface matmul_engine_if #(
  parameter int DATA_WIDTH = matmul_pkg::DATA_WIDTH_DEF
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/matmul_engine_mac.sv
// matmul_mac: signed multiply-accumulate unit.
// clk, reset : clock and asynchronous active-high reset
// clear      : zero the accumulator (wins over enable)
// enable     : add a*b to the accumulator
// a, b       : signed operands
// acc        : signed running sum, ACC_WIDTH bits
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] product;

  // Full-width signed product; no bits are dropped before accumulation.
  always_comb begin
    product = a * b;
  end

  // The size cast sign-extends the product up to the accumulator width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + ACC_WIDTH'(product);
    end
  end

endmodule

// File: rtl/matmul_engine.sv
// matmul_engine: streaming C = A x B with runtime dimensions up to M.
// clk, reset                 : clock and asynchronous active-high reset
// start                      : begin a job (only looked at in IDLE)
// n_rows, n_inner, n_cols    : A is n_rows x n_inner, B is n_inner x n_cols
// io (slave)                 : operand stream in, result stream out
// busy                       : high whenever not IDLE
// done                       : one-cycle pulse as the engine returns to IDLE
// err                        : last start carried an out-of-range dimension
module matmul_engine
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int M          = M_DEF,
  parameter bit SATURATE   = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [$clog2(M):0] n_rows,
  input  logic [$clog2(M):0] n_inner,
  input  logic [$clog2(M):0] n_cols,
  matmul_engine_if.slave     io,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int DIM_BITS  = $clog2(M) + 1;
  localparam int ACC_BITS  = 2 * DATA_WIDTH + $clog2(M);
  localparam int ADDR_BITS = $clog2(M * M);
  localparam int CNT_BITS  = 2 * DIM_BITS;
  localparam int DEPTH     = M * M;

  localparam logic signed [ACC_BITS-1:0] SAT_HI =
    {{(ACC_BITS-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_BITS-1:0] SAT_LO =
    {{(ACC_BITS-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  state_t state, state_next;

  logic [DIM_BITS-1:0]  rows_q, inner_q, cols_q;
  logic [DIM_BITS-1:0]  row_i, col_j, k_cnt;
  logic [CNT_BITS-1:0]  ld_cnt, total_a, total_b;
  logic [ADDR_BITS-1:0] a_base, b_off, a_idx, b_idx;
  logic                 dims_ok, accept, last_a, last_b, last_elem;
  logic                 rd_en, mac_clear, mac_en;

  logic [DATA_WIDTH-1:0] a_mem [DEPTH];
  logic [DATA_WIDTH-1:0] b_mem [DEPTH];
  logic signed [DATA_WIDTH-1:0] a_rd, b_rd;
  logic signed [ACC_BITS-1:0]   acc;
  logic [DATA_WIDTH-1:0]        wrap_val, sat_val;

  // Beat and element bookkeeping. A is stored with stride n_inner and B with
  // stride n_cols, so element (i,j) walks A at i*n_inner+k and B at k*n_cols+j.
  // Both bases are kept incrementally to avoid multipliers in the read path.
  always_comb begin
    dims_ok   = (n_rows  != '0) && (n_rows  <= DIM_BITS'(M)) &&
                (n_inner != '0) && (n_inner <= DIM_BITS'(M)) &&
                (n_cols  != '0) && (n_cols  <= DIM_BITS'(M));
    accept    = io.in_valid && io.in_ready;
    total_a   = CNT_BITS'(rows_q) * CNT_BITS'(inner_q);
    total_b   = CNT_BITS'(inner_q) * CNT_BITS'(cols_q);
    last_a    = (ld_cnt == total_a - CNT_BITS'(1));
    last_b    = (ld_cnt == total_b - CNT_BITS'(1));
    last_elem = (row_i == rows_q - DIM_BITS'(1)) && (col_j == cols_q - DIM_BITS'(1));
    a_idx     = a_base + ADDR_BITS'(k_cnt);
    b_idx     = b_off + ADDR_BITS'(col_j);
    // MAC cycle 0 only issues the first read; the sums start one cycle later.
    rd_en     = (state == MAC) && (k_cnt != inner_q);
    mac_clear = (state == MAC) && (k_cnt == '0);
    mac_en    = (state == MAC) && (k_cnt != '0);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next   = state;
    io.in_ready  = 1'b0;
    io.out_valid = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (start && dims_ok) state_next = LOAD_A;
      end
      LOAD_A: begin
        io.in_ready = 1'b1;
        if (accept && last_a) state_next = LOAD_B;
      end
      LOAD_B: begin
        io.in_ready = 1'b1;
        if (accept && last_b) state_next = MAC;
      end
      MAC: begin
        if (k_cnt == inner_q) state_next = EMIT;
      end
      EMIT: begin
        io.out_valid = 1'b1;
        if (io.out_ready) state_next = last_elem ? IDLE : MAC;
      end
      default: state_next = IDLE;
    endcase
  end

  // Dimension latch, counters, address bases, error flag and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_q  <= '0;
      inner_q <= '0;
      cols_q  <= '0;
      row_i   <= '0;
      col_j   <= '0;
      k_cnt   <= '0;
      ld_cnt  <= '0;
      a_base  <= '0;
      b_off   <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= (state == EMIT) && io.out_ready && last_elem;
      case (state)
        IDLE: begin
          if (start && dims_ok) begin
            rows_q  <= n_rows;
            inner_q <= n_inner;
            cols_q  <= n_cols;
            ld_cnt  <= '0;
            err     <= 1'b0;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        LOAD_A: begin
          if (accept) ld_cnt <= last_a ? '0 : ld_cnt + CNT_BITS'(1);
        end
        LOAD_B: begin
          if (accept) begin
            if (last_b) begin
              ld_cnt <= '0;
              row_i  <= '0;
              col_j  <= '0;
              k_cnt  <= '0;
              a_base <= '0;
              b_off  <= '0;
            end else begin
              ld_cnt <= ld_cnt + CNT_BITS'(1);
            end
          end
        end
        MAC: begin
          if (k_cnt != inner_q) begin
            k_cnt <= k_cnt + DIM_BITS'(1);
            b_off <= b_off + ADDR_BITS'(cols_q);
          end
        end
        EMIT: begin
          if (io.out_ready) begin
            k_cnt <= '0;
            b_off <= '0;
            if (col_j == cols_q - DIM_BITS'(1)) begin
              col_j  <= '0;
              row_i  <= row_i + DIM_BITS'(1);
              a_base <= a_base + ADDR_BITS'(inner_q);
            end else begin
              col_j <= col_j + DIM_BITS'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Operand buffers: one write per accepted beat, one registered read per
  // MAC cycle. Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && (state == LOAD_A)) a_mem[ld_cnt[ADDR_BITS-1:0]] <= io.in_data;
    if (accept && (state == LOAD_B)) b_mem[ld_cnt[ADDR_BITS-1:0]] <= io.in_data;
    if (rd_en) begin
      a_rd <= a_mem[a_idx];
      b_rd <= b_mem[b_idx];
    end
  end

  matmul_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_BITS)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (mac_clear),
    .enable(mac_en),
    .a     (a_rd),
    .b     (b_rd),
    .acc   (acc)
  );

  // Result formatting: either the low bits of the sum or the sum clamped to
  // the element range. The bus reads zero whenever nothing is offered.
  always_comb begin
    wrap_val = acc[DATA_WIDTH-1:0];
    sat_val  = acc[DATA_WIDTH-1:0];
    if (acc > SAT_HI) begin
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (acc < SAT_LO) begin
      sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
    io.out_data = '0;
    if (state == EMIT) io.out_data = SATURATE ? sat_val : wrap_val;
  end

endmodule

// File: tb/tb_matmul_engine.sv
// Directed bench for matmul_engine. Two engines (wrapping and saturating)
// share one stimulus stream so both output modes are checked side by side.
module tb_matmul_engine;
  import matmul_pkg::*;

  logic             clk;
  logic             reset;
  logic             start;
  logic [DIM_W-1:0] n_rows, n_inner, n_cols;
  logic             in_valid;
  element_t         in_data;
  logic             out_ready;
  logic             busy_w, done_w, err_w;
  logic             busy_s, done_s, err_s;

  int compare_count;
  int mismatch_count;

  int a_vals [1024];
  int b_vals [1024];
  int exp_w  [1024];
  int exp_s  [1024];

  matmul_engine_if #(.DATA_WIDTH(DATA_WIDTH_DEF)) ifw ();
  matmul_engine_if #(.DATA_WIDTH(DATA_WIDTH_DEF)) ifs ();

  assign ifw.in_valid  = in_valid;
  assign ifw.in_data   = in_data;
  assign ifw.out_ready = out_ready;
  assign ifs.in_valid  = in_valid;
  assign ifs.in_data   = in_data;
  assign ifs.out_ready = out_ready;

  matmul_engine #(.DATA_WIDTH(DATA_WIDTH_DEF), .M(M_DEF), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .start(start),
    .n_rows(n_rows), .n_inner(n_inner), .n_cols(n_cols),
    .io(ifw), .busy(busy_w), .done(done_w), .err(err_w)
  );

  matmul_engine #(.DATA_WIDTH(DATA_WIDTH_DEF), .M(M_DEF), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .start(start),
    .n_rows(n_rows), .n_inner(n_inner), .n_cols(n_cols),
    .io(ifs), .busy(busy_s), .done(done_s), .err(err_s)
  );

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference product used for the random job: plain triple loop.
  task automatic computeModel(input int r, input int k, input int c);
    acc_t sum;
    for (int i = 0; i < r; i++) begin
      for (int j = 0; j < c; j++) begin
        sum = '0;
        for (int p = 0; p < k; p++) begin
          sum = sum + acc_t'(a_vals[i*k+p]) * acc_t'(b_vals[p*c+j]);
        end
        exp_w[i*c+j] = int'($signed(sum[15:0]));
        if (sum > acc_t'(32767))       exp_s[i*c+j] = 32767;
        else if (sum < acc_t'(-32768)) exp_s[i*c+j] = -32768;
        else                           exp_s[i*c+j] = int'(sum);
      end
    end
  endtask

  // Issue a start and stream A then B; stops after stop_at accepted beats.
  task automatic applyStimulus(input int r, input int k, input int c,
                               input int stop_at, input bit hold_start);
    int  idx;
    int  guard;
    int  total;
    bit  took;
    total = r*k + k*c;
    @(negedge clk);
    start   = 1'b1;
    n_rows  = DIM_W'(r);
    n_inner = DIM_W'(k);
    n_cols  = DIM_W'(c);
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    checkOutput("busy_after_start", int'(busy_w), 1);
    checkOutput("err_after_start", int'(err_w), 0);
    idx   = 0;
    guard = 0;
    while (idx < stop_at && guard < total + 50) begin
      in_valid = 1'b1;
      if (idx < r*k) in_data = element_t'(a_vals[idx]);
      else           in_data = element_t'(b_vals[idx - r*k]);
      took = ifw.in_ready;
      @(negedge clk);
      if (took) idx++;
      guard++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    start    = 1'b0;
    checkOutput("load_beats", idx, stop_at);
  endtask

  // Drain results, optionally stalling the first element for some cycles.
  task automatic collectOutputs(input int total, input int inner, input int stall);
    int e, gap, guard, stall_left;
    bit seen, stalled_prev;
    e = 0; gap = 0; guard = 0; stall_left = stall;
    seen = 1'b0; stalled_prev = 1'b0;
    out_ready = 1'b1;
    while (e < total && guard < total*(inner+3) + stall + 200) begin
      @(negedge clk);
      guard++;
      if (ifw.out_valid) begin
        checkOutput("out_wrap", int'($signed(ifw.out_data)), exp_w[e]);
        checkOutput("out_sat", int'($signed(ifs.out_data)), exp_s[e]);
        checkOutput("no_early_done", int'(done_w), 0);
        if (!seen && e > 0) checkOutput("emit_gap", gap, inner + 1);
        seen = 1'b1;
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          stalled_prev = 1'b1;
        end else begin
          out_ready = 1'b1;
          e++;
          gap = 0;
          seen = 1'b0;
          stalled_prev = 1'b0;
        end
      end else begin
        if (stalled_prev) checkOutput("stall_hold_valid", int'(ifw.out_valid), 1);
        stalled_prev = 1'b0;
        out_ready = 1'b1;
        gap++;
      end
    end
    out_ready = 1'b1;
    checkOutput("out_count", e, total);
    @(negedge clk);
    checkOutput("done_pulse", int'(done_w), 1);
    checkOutput("done_pulse_sat", int'(done_s), 1);
    checkOutput("busy_at_done", int'(busy_w), 0);
    @(negedge clk);
    checkOutput("done_single", int'(done_w), 0);
    checkOutput("busy_after_done", int'(busy_w), 0);
  endtask

  // Everything observable should read zero while reset is applied.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, int'(ifw.in_ready), 0);
    checkOutput({tag, "_out_valid"}, int'(ifw.out_valid), 0);
    checkOutput({tag, "_out_data"}, int'(ifw.out_data), 0);
    checkOutput({tag, "_busy"}, int'(busy_w), 0);
    checkOutput({tag, "_done"}, int'(done_w), 0);
    checkOutput({tag, "_err"}, int'(err_w), 0);
  endtask

  // Scenario sequence.
  initial begin
    compare_count  = 0;
    mismatch_count = 0;
    reset     = 1'b1;
    start     = 1'b0;
    n_rows    = '0;
    n_inner   = '0;
    n_cols    = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkResetOutputs("por");
    reset = 1'b0;
    @(negedge clk);
    checkResetOutputs("post_por");

    // 2x2x2 basic product.
    $display("[TB] 2x2x2 product");
    a_vals[0:3] = '{1, 2, 3, 4};
    b_vals[0:3] = '{5, 6, 7, 8};
    exp_w[0:3]  = '{19, 22, 43, 50};
    exp_s[0:3]  = '{19, 22, 43, 50};
    applyStimulus(2, 2, 2, 8, 1'b0);
    collectOutputs(4, 2, 0);

    // Bad dimensions are rejected and flagged.
    $display("[TB] dimension errors");
    @(negedge clk);
    start = 1'b1; n_rows = 2; n_inner = 0; n_cols = 2;
    in_valid = 1'b1; in_data = 5;
    @(negedge clk);
    start = 1'b0;
    checkOutput("err_inner0", int'(err_w), 1);
    checkOutput("busy_inner0", int'(busy_w), 0);
    checkOutput("ready_inner0", int'(ifw.in_ready), 0);
    repeat (2) begin
      @(negedge clk);
      checkOutput("ready_idle_err", int'(ifw.in_ready), 0);
      checkOutput("busy_idle_err", int'(busy_w), 0);
    end
    start = 1'b1; n_rows = 33; n_inner = 2; n_cols = 2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    checkOutput("err_rows33", int'(err_w), 1);
    checkOutput("busy_rows33", int'(busy_w), 0);
    checkOutput("ready_rows33", int'(ifw.in_ready), 0);

    // 1x1x1 with a negative operand; also clears err.
    $display("[TB] 1x1x1 product");
    a_vals[0] = -3;
    b_vals[0] = 7;
    exp_w[0]  = -21;
    exp_s[0]  = -21;
    applyStimulus(1, 1, 1, 2, 1'b0);
    collectOutputs(1, 1, 0);

    // 2x2x2 again, first result stalled, start held high during the load.
    $display("[TB] 2x2x2 with back-pressure");
    a_vals[0:3] = '{1, 2, 3, 4};
    b_vals[0:3] = '{5, 6, 7, 8};
    exp_w[0:3]  = '{19, 22, 43, 50};
    exp_s[0:3]  = '{19, 22, 43, 50};
    applyStimulus(2, 2, 2, 8, 1'b1);
    collectOutputs(4, 2, 10);

    // Full-size job of maximum positive values: wrap gives 32, clamp 32767.
    $display("[TB] 32x32x32 full scale");
    for (int i = 0; i < 1024; i++) begin
      a_vals[i] = 32767;
      b_vals[i] = 32767;
      exp_w[i]  = 32;
      exp_s[i]  = 32767;
    end
    applyStimulus(32, 32, 32, 2048, 1'b0);
    collectOutputs(1024, 32, 0);

    // Reset in the middle of loading B, then a fresh random job.
    $display("[TB] reset mid-load then 13x17x19");
    for (int i = 0; i < 1024; i++) begin
      a_vals[i] = int'($urandom_range(3, 0));
      b_vals[i] = int'($urandom_range(3, 0));
    end
    applyStimulus(13, 17, 19, 13*17 + 100, 1'b0);
    checkOutput("busy_mid_load_b", int'(busy_w), 1);
    checkOutput("ready_mid_load_b", int'(ifw.in_ready), 1);
    reset = 1'b1;
    #1;
    checkResetOutputs("mid_reset");
    repeat (2) @(negedge clk);
    checkResetOutputs("mid_reset_hold");
    reset = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      a_vals[i] = int'($urandom_range(3, 0));
      b_vals[i] = int'($urandom_range(3, 0));
    end
    computeModel(13, 17, 19);
    applyStimulus(13, 17, 19, 13*17 + 17*19, 1'b0);
    collectOutputs(13*19, 17, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
